// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared FSM type, coin values and money width for vend_settlement
// Revision : 1.0
// ============================================================================
package vend_pkg;

   localparam int MONEY_W = 64;

   localparam logic [MONEY_W-1:0] COIN_5   = 64'd5;
   localparam logic [MONEY_W-1:0] COIN_10  = 64'd10;
   localparam logic [MONEY_W-1:0] COIN_25  = 64'd25;
   localparam logic [MONEY_W-1:0] COIN_100 = 64'd100;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] coin_type);
      logic [MONEY_W-1:0] val;
      case (coin_type)
         2'd0:    val = COIN_5;
         2'd1:    val = COIN_10;
         2'd2:    val = COIN_25;
         default: val = COIN_100;
      endcase
      return val;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_credit_acc.sv
`default_nettype none
// ============================================================================
// vend_credit_acc : credit register with ceiling-checked add and accept/reject pulses
// Revision : 1.0
// ============================================================================
module vend_credit_acc
   import vend_pkg::*;
#(
   parameter logic [MONEY_W-1:0] MAX_CREDIT = 64'd1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               coin_valid,
   input  logic [1:0]         coin_type,
   input  logic               coin_allow,
   input  logic               clear,
   output logic               coin_ok,
   output logic [MONEY_W-1:0] credit,
   output logic               coin_accept,
   output logic               coin_reject
);

   logic [MONEY_W-1:0] coin_val;
   logic [MONEY_W-1:0] credit_d, credit_q;
   logic               coin_accept_d, coin_accept_q;
   logic               coin_reject_d, coin_reject_q;

   always_comb begin
      coin_val = coin_value(coin_type);
      // credit never exceeds MAX_CREDIT, so the subtraction cannot wrap
      coin_ok       = coin_valid && coin_allow && (coin_val <= (MAX_CREDIT - credit_q));
      coin_accept_d = coin_ok;
      coin_reject_d = coin_valid && !coin_ok;
      credit_d      = credit_q;
      if (clear) begin
         credit_d = '0;
      end else if (coin_ok) begin
         credit_d = credit_q + coin_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_q      <= '0;
         coin_accept_q <= 1'b0;
         coin_reject_q <= 1'b0;
      end else begin
         credit_q      <= credit_d;
         coin_accept_q <= coin_accept_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign credit      = credit_q;
   assign coin_accept = coin_accept_q;
   assign coin_reject = coin_reject_q;

endmodule
`default_nettype wire

// File: rtl/vend_settlement.sv
`default_nettype none
// ============================================================================
// vend_settlement : payment-side settlement FSM, price latch and change computation
// Revision : 1.0
// ============================================================================
module vend_settlement
   import vend_pkg::*;
#(
   parameter logic [MONEY_W-1:0] PRICE      = 64'd150,
   parameter logic [MONEY_W-1:0] MAX_CREDIT = 64'd1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sell_signal,
   input  logic [MONEY_W-1:0] total_discount,
   input  logic               coin_valid,
   input  logic [1:0]         coin_type,
   input  logic               cancel,
   input  logic               dispense_ready,
   input  logic               change_ready,
   output logic               dispense_valid,
   output logic               change_valid,
   output logic [MONEY_W-1:0] change_amount,
   output logic               coin_accept,
   output logic               coin_reject,
   output logic [MONEY_W-1:0] credit,
   output logic               busy
);

   state_t             state_d, state_q;
   logic [MONEY_W-1:0] eff_price_d, eff_price_q;
   logic [MONEY_W-1:0] change_amount_d, change_amount_q;
   logic [MONEY_W-1:0] price_now;
   logic               coin_allow;
   logic               coin_ok;
   logic               credit_clear;

   // Kept outside the next-state block so coin_ok does not loop back into it
   assign coin_allow = (state_q == ST_IDLE) || ((state_q == ST_COLLECT) && !cancel);

   vend_credit_acc #(
      .MAX_CREDIT (MAX_CREDIT)
   ) u_credit_acc (
      .clk         (clk),
      .reset       (reset),
      .coin_valid  (coin_valid),
      .coin_type   (coin_type),
      .coin_allow  (coin_allow),
      .clear       (credit_clear),
      .coin_ok     (coin_ok),
      .credit      (credit),
      .coin_accept (coin_accept),
      .coin_reject (coin_reject)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         eff_price_q     <= '0;
         change_amount_q <= '0;
      end else begin
         state_q         <= state_d;
         eff_price_q     <= eff_price_d;
         change_amount_q <= change_amount_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      eff_price_d     = eff_price_q;
      change_amount_d = change_amount_q;
      credit_clear    = 1'b0;
      price_now       = (PRICE > total_discount) ? (PRICE - total_discount) : '0;
      case (state_q)
         ST_IDLE: begin
            if (coin_ok) begin
               eff_price_d = price_now;
               state_d     = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (cancel) begin
               change_amount_d = credit;
               state_d         = ST_CHANGE;
            end else if ((credit >= eff_price_q) && sell_signal) begin
               state_d = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            if (dispense_ready) begin
               change_amount_d = credit - eff_price_q;
               if (credit == eff_price_q) begin
                  credit_clear = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_CHANGE;
               end
            end
         end
         ST_CHANGE: begin
            if (change_ready) begin
               credit_clear    = 1'b1;
               change_amount_d = '0;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dispense_valid = (state_q == ST_DISPENSE);
      change_valid   = (state_q == ST_CHANGE);
      busy           = (state_q != ST_IDLE);
   end

   assign change_amount = change_amount_q;

endmodule
`default_nettype wire

// File: doc/vend_settlement.md
# vend_settlement

Payment-side settlement controller for the vending machine. It accepts coins, latches the discounted price at the start of each transaction, and waits for the controller's `sell_signal`/`total_discount` pair to permit a sale. It then hands the dispense and change events to the downstream actuators through valid/ready handshakes. It consumes the vending controller's outputs and drives the product and coin-return mechanics.

## Interface
Parameters:
- `PRICE`, default 150: list price in cents; 64-bit unsigned.
- `MAX_CREDIT`, default 1000: credit ceiling in cents.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `sell_signal`  in  1  sale permitted (level, from the vending controller).
- `total_discount`  in  64  discount in cents (from the vending controller).
- `coin_valid`  in  1  one-cycle coin-insert strobe.
- `coin_type`  in  2  coin value: 0 = 5, 1 = 10, 2 = 25, 3 = 100.
- `cancel`  in  1  one-cycle abort request.
- `dispense_ready`  in  1  product actuator ready.
- `change_ready`  in  1  coin-return actuator ready.
- `dispense_valid`  out  1  product dispense request.
- `change_valid`  out  1  change-return request.
- `change_amount`  out  64  change in cents; valid while `change_valid` is high.
- `coin_accept`  out  1  one-cycle pulse: previous-cycle coin was accepted.
- `coin_reject`  out  1  one-cycle pulse: previous-cycle coin was rejected (returned).
- `credit`  out  64  current credit.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE. The state encoding lives in the package.
- Effective price `eff_price` = `PRICE > total_discount ? PRICE - total_discount : 0`.
  - Saturating; never negative.
  - Latched once, at the accepted first coin in IDLE; held for the whole transaction.
- IDLE: `credit` = 0.
  - Coin arrives: `credit` = coin value, latch `eff_price`, go to COLLECT.
  - `cancel` is ignored.
- COLLECT, priority order:
  1. `cancel`: load `change_amount` = `credit`, go to CHANGE. A coin in the same cycle is rejected.
  2. Coin arrives: accepted if `credit + value <= MAX_CREDIT`, otherwise rejected and `credit` is unchanged.
  3. `credit >= eff_price` and `sell_signal` = 1: go to DISPENSE. This uses the registered `credit`. An accepted coin in the same cycle is still added.
  4. Otherwise hold. `sell_signal` = 0 holds COLLECT indefinitely.
- DISPENSE:
  - `dispense_valid` = 1 until `dispense_ready`.
  - On handshake: `change_amount` = `credit - eff_price`. If zero, clear `credit` and go to IDLE; else go to CHANGE.
  - `cancel` is ignored.
- CHANGE:
  - `change_valid` = 1 with `change_amount` stable until `change_ready`.
  - On handshake: clear `credit` and `change_amount`, go to IDLE.
- A coin in DISPENSE or CHANGE is always rejected.
- Arithmetic: 64-bit unsigned. Coin values are zero-extended. The credit addition is checked against `MAX_CREDIT` before commit, so no wrap is possible.

## Timing
- Reset values: state IDLE; every output 0; latched `eff_price` 0.
- Reset mid-transaction:
  - Credit is discarded.
  - No dispense or change is issued.
  - Outputs drop asynchronously.
- All outputs are registered or decoded from the state register. There is no combinational input-to-output path.
- Coin at edge N:
  - `coin_accept`/`coin_reject` pulse high during cycle N+1.
  - `credit` is updated in cycle N+1.
- The earliest DISPENSE entry is the edge after the cycle in which the updated `credit` satisfies the price: the last coin is at N, `dispense_valid` rises at N+2.
- `dispense_valid` and `change_valid` are never high together.
  - DISPENSE→CHANGE transfer: `change_valid` rises the cycle after the dispense handshake.
- Valid signals stay high and payloads stay stable until their ready is seen. Ready asserted while valid is low has no effect.

## Structure
- Package `vend_pkg` holds:
  - the state typedef (2-bit);
  - the coin-value constants 5/10/25/100;
  - the function `coin_value(coin_type)`;
  - the 64-bit money width constant.
- Sub-module `vend_credit_acc`: the credit register, the MAX_CREDIT-checked add, the accept/reject pulse generation, and clear.
- The top holds the FSM, the price latch and the change computation.

## Test plan
- **Full price:** `PRICE` = 150, discount 0, `sell_signal` = 1, coins 100, 25, 25 → `credit` 150, `dispense_valid` = 1; after `dispense_ready` → IDLE, `change_valid` never asserted.
- **Discount with change:** discount 40, coins 100, 25 → dispense; then `change_valid` with `change_amount` = 15; `change_ready` → IDLE, `credit` = 0.
- **Discount above price:** discount 200, coin 25 → `eff_price` = 0, dispense, then change 25. Also change `total_discount` mid-transaction → latched price unchanged.
- **Cancel:** coins 10, 5, then `cancel` → `change_amount` = 15, no dispense. `cancel` coinciding with a coin → `coin_reject` pulse, change still 15.
- **Credit ceiling and sell gate:** `MAX_CREDIT` = 200, `sell_signal` = 0, coins 100, 100, 5 → third coin rejected, `credit` = 200, stays in COLLECT. Raising `sell_signal` → dispense, change 50.
- **Reset mid-dispense:** reset in DISPENSE with `dispense_ready` low → all outputs 0 immediately, state IDLE, next coin starts a fresh transaction.
